msrv32_prefetch_buffer: RTL

MSRV32_PREFETCH_BUFFER -- requirements
Module: msrv32_prefetch_buffer

---
 rtl/msrv32_pkg.sv | 16 +
 rtl/msrv32_sync_fifo.sv | 47 ++++
 rtl/msrv32_prefetch_buffer.sv | 112 +++++++++++
 3 files changed

// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared types and constants for the msrv32 instruction prefetch path
package msrv32_pkg;

    typedef enum logic [0:0] {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [1:0]  INSTR_ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [31:0] pc);
        return (pc[1:0] & INSTR_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/msrv32_sync_fifo.sv
// rtl/msrv32_sync_fifo.sv - power-of-two synchronous FIFO with flush; pop and push may coincide when full
module msrv32_sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             full, do_push, do_pop;

    assign empty_o    = (count_q == '0);
    assign full       = (count_q == (AW+1)'(DEPTH));
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full || do_pop);
    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
            else if (!do_push && do_pop) count_q <= count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/msrv32_prefetch_buffer.sv
// rtl/msrv32_prefetch_buffer.sv - instruction prefetcher with in-order memory responses, redirect flush and misalignment halt
module msrv32_prefetch_buffer
    import msrv32_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    output logic [31:0] ms_riscv32_mp_imaddr_out,
    output logic        imreq_valid_out,
    input  logic        imreq_ready_in,
    input  logic [31:0] ms_riscv32_mp_instr_in,
    input  logic        instr_valid_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        misaligned_instr_out
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;
    logic [63:0]   fifo_rdata;
    logic [31:0]   resp_pc;
    logic          fifo_empty, fifo_push, fifo_pop, req_fire;

    assign occupancy = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign req_fire  = imreq_valid_out && imreq_ready_in;
    // With nothing left to discard, every in-flight request is sequential, so the oldest one's address is implied.
    assign resp_pc   = fetch_pc_q - 32'({outstanding_q, 2'b00});
    assign ms_riscv32_mp_imaddr_out = fetch_pc_q;

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) state_q <= ST_FETCH;
        else                      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (redirect_in) state_d = is_misaligned(redirect_pc_in) ? ST_HALTED : ST_FETCH;
    end

    always_comb begin
        imreq_valid_out      = 1'b0;
        misaligned_instr_out = 1'b0;
        if (!ms_riscv32_mp_rst_in) begin
            imreq_valid_out      = (state_q == ST_FETCH) && !redirect_in && (occupancy < DEPTH_V);
            misaligned_instr_out = (state_q == ST_HALTED);
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (req_fire && !instr_valid_in)      outstanding_d = outstanding_q + CW'(1);
        else if (!req_fire && instr_valid_in) outstanding_d = outstanding_q - CW'(1);
        discard_d  = discard_q;
        fetch_pc_d = fetch_pc_q;
        fifo_push  = 1'b0;
        if (redirect_in) begin
            discard_d  = outstanding_d;
            fetch_pc_d = redirect_pc_in;
        end else begin
            if (instr_valid_in) begin
                if (discard_q != '0) discard_d = discard_q - CW'(1);
                else                 fifo_push = 1'b1;
            end
            if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    assign valid_out = !fifo_empty && !ms_riscv32_mp_rst_in;
    assign fifo_pop  = valid_out && ready_in;
    assign instr_out = valid_out ? fifo_rdata[31:0]  : 32'h0;
    assign pc_out    = valid_out ? fifo_rdata[63:32] : 32'h0;

    msrv32_sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (ms_riscv32_mp_clk_in),
        .rst_i       (ms_riscv32_mp_rst_in),
        .clear_i     (redirect_in),
        .push_i      (fifo_push),
        .push_data_i ({resp_pc, ms_riscv32_mp_instr_in}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rdata),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule
